// File: rtl/zc_measure_ctrl.sv
// zc_measure_ctrl
//
// Measurement sequencer for the zero-crossing detector. A command reprograms
// the detector threshold and runs cmd_num_win back-to-back windows. Each
// window is cmd_win_len accepted samples long and is preceded by a one-cycle
// detector clear. The number of crossings seen in each window goes out as
// one beat on the result stream.
//
// Ports
//   clk, reset_n           clock, asynchronous active-low reset
//   abort                  synchronous level abort; forces IDLE next cycle
//   cmd_threshold/win_len/num_win, cmd_valid/cmd_ready   command in
//   cmd_err                one-cycle pulse when a command is rejected
//   det_threshold          registered detector threshold
//   det_clear              one-cycle detector clear before each window
//   det_en                 sample-stream gate, high only while counting
//   s_beat, zc_pulse       accepted sample / crossing event from detector
//   o_tdata/o_tuser/o_tlast/o_tvalid/o_tready   result stream
//   busy                   high whenever a command is in progress
//   dbg_state              current FSM state (IDLE=0, CLEAR=1, RUN=2, OUT=3)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and its payload stable until that
// edge and never withdraws valid on its own; only abort or reset may drop
// o_tvalid before the transfer completes.

module zc_measure_ctrl #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 32,
  parameter int N_WIN_MAX = 16,
  localparam int NW       = $clog2(N_WIN_MAX + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     cmd_threshold,
  input  logic [CNT_WIDTH-1:0] cmd_win_len,
  input  logic [NW-1:0]        cmd_num_win,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  output logic                 cmd_err,
  output logic [WIDTH-1:0]     det_threshold,
  output logic                 det_clear,
  output logic                 det_en,
  input  logic                 s_beat,
  input  logic                 zc_pulse,
  output logic [CNT_WIDTH-1:0] o_tdata,
  output logic                 o_tuser,
  output logic                 o_tlast,
  output logic                 o_tvalid,
  input  logic                 o_tready,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  localparam logic [NW-1:0] NUM_WIN_MAX = NW'(N_WIN_MAX);

  state_t               state;
  state_t               state_nxt;
  logic [CNT_WIDTH-1:0] win_len;
  logic [CNT_WIDTH-1:0] samp_cnt;
  logic [CNT_WIDTH-1:0] zc_cnt;
  logic [NW-1:0]        num_win;
  logic [NW-1:0]        win_idx;
  logic                 sat;

  logic cmd_fire;
  logic cmd_bad;
  logic win_close;
  logic last_win;
  logic out_fire;

  assign cmd_fire  = cmd_valid & cmd_ready;
  assign cmd_bad   = (cmd_num_win == '0) | (cmd_num_win > NUM_WIN_MAX) |
                     (cmd_win_len == '0);
  // The closing beat is the one that brings the sample count to win_len.
  assign win_close = s_beat & (samp_cnt == win_len - CNT_WIDTH'(1));
  assign last_win  = (win_idx == num_win - NW'(1));
  assign out_fire  = (state == S_OUT) & o_tready;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; abort overrides everything
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (cmd_fire && !cmd_bad) state_nxt = S_CLEAR;
        S_CLEAR: state_nxt = S_RUN;
        S_RUN:   if (win_close) state_nxt = S_OUT;
        S_OUT:   if (o_tready) state_nxt = last_win ? S_IDLE : S_CLEAR;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Command latch, counters and the rejection pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_len       <= '0;
      num_win       <= '0;
      win_idx       <= '0;
      samp_cnt      <= '0;
      zc_cnt        <= '0;
      sat           <= 1'b0;
      det_threshold <= '0;
      cmd_err       <= 1'b0;
    end else begin
      cmd_err <= cmd_fire & cmd_bad;
      if (cmd_fire && !cmd_bad) begin
        win_len       <= cmd_win_len;
        num_win       <= cmd_num_win;
        det_threshold <= cmd_threshold;
        win_idx       <= '0;
      end
      case (state)
        S_CLEAR: begin
          samp_cnt <= '0;
          zc_cnt   <= '0;
          sat      <= 1'b0;
        end
        S_RUN: begin
          if (s_beat) samp_cnt <= samp_cnt + CNT_WIDTH'(1);
          // A crossing arriving with the counter already full is lost;
          // sat records that the reported count is a lower bound.
          if (zc_pulse) begin
            if (&zc_cnt) sat    <= 1'b1;
            else         zc_cnt <= zc_cnt + CNT_WIDTH'(1);
          end
        end
        S_OUT: begin
          if (out_fire && !last_win) win_idx <= win_idx + NW'(1);
        end
        default: ;
      endcase
    end
  end

  // Moore outputs decoded from registered state and counters
  always_comb begin
    cmd_ready = reset_n & (state == S_IDLE) & ~abort;
    det_clear = (state == S_CLEAR);
    det_en    = (state == S_RUN);
    o_tvalid  = (state == S_OUT);
    o_tdata   = zc_cnt;
    o_tuser   = (state == S_OUT) & sat;
    o_tlast   = (state == S_OUT) & last_win;
    busy      = (state != S_IDLE);
    dbg_state = state;
  end

endmodule
